// File: rtl/timer_up_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_up_pkg
// Description : Shared constants, state encodings and digit helper for the
//               count-up MM:SS BCD timer.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_up_pkg;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    localparam logic [15:0] BCD_MAX_TIME = 16'h9959;
    localparam logic [15:0] FREE_RUN     = 16'h0000;

    localparam int c_sec_tens_mod = 6;
    localparam int c_dig_mod      = 10;

    // Value a digit takes after one clock given its increment request.
    function automatic logic [3:0] bcd_digit_next(input logic [3:0] digit,
                                                  input logic       inc,
                                                  input logic [3:0] max_digit);
        if (!inc)
            return digit;
        if (digit == max_digit)
            return 4'h0;
        return digit + 4'h1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_up.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_up
// Description : One up-counting BCD digit with sanitising load and carry out.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_up
    import timer_up_pkg::*;
#(
    parameter int MOD = c_dig_mod
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry
);

    localparam logic [3:0] c_max = 4'(MOD - 1);

    logic [3:0] r_digit;

    // Out-of-range load digits fall back to zero.
    always_ff @(posedge clk) begin
        if (rst)
            r_digit <= 4'h0;
        else if (clear)
            r_digit <= 4'h0;
        else if (load)
            r_digit <= (load_digit > c_max) ? 4'h0 : load_digit;
        else
            r_digit <= bcd_digit_next(r_digit, inc, c_max);
    end

    assign digit = r_digit;
    assign carry = inc && (r_digit == c_max);

endmodule
`default_nettype wire

// File: rtl/timer_up_bcd.sv
`default_nettype none
// ============================================================================
// Module      : timer_up_bcd
// Description : MM:SS BCD count-up timer with limit detect and rollover carry.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_up_bcd
    import timer_up_pkg::*;
#(
    parameter int SEC_TENS_MOD = c_sec_tens_mod,
    parameter int DIG_MOD      = c_dig_mod
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enablen,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic [15:0] limit,
    input  logic        tick,
    output logic [15:0] count,
    output logic        rco_L,
    output logic        done,
    output logic        running
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        w_advance;
    logic [3:0]  w_inc;
    logic [3:0]  w_carry;
    logic [15:0] w_count;
    logic [15:0] w_next_count;

    assign w_advance = (r_state == S_RUN) && tick && !enablen;
    assign w_inc     = {w_carry[2:0], w_advance};

    // Digit 0 = seconds ones ... digit 3 = minutes tens.
    for (genvar i = 0; i < 4; i++) begin : g_digit
        localparam int c_mod = (i == 1) ? SEC_TENS_MOD : DIG_MOD;

        bcd_digit_up #(
            .MOD(c_mod)
        ) u_digit (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear),
            .load      (load),
            .load_digit(load_value[4*i +: 4]),
            .inc       (w_inc[i]),
            .digit     (w_count[4*i +: 4]),
            .carry     (w_carry[i])
        );

        assign w_next_count[4*i +: 4] =
            bcd_digit_next(w_count[4*i +: 4], w_inc[i], 4'(c_mod - 1));
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (clear || load) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (!enablen) w_state_next = S_RUN;
                S_RUN: begin
                    if (enablen)
                        w_state_next = S_PAUSE;
                    else if (w_advance && (w_next_count == limit) && (limit != FREE_RUN))
                        w_state_next = S_DONE;
                end
                S_PAUSE: if (!enablen) w_state_next = S_RUN;
                S_DONE:  w_state_next = S_DONE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // The top digit only carries when an advance sees 99:59.
    assign rco_L   = !w_carry[3];
    assign count   = w_count;
    assign done    = (r_state == S_DONE);
    assign running = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_timer_up_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_up_bcd
// Description : Scoreboard bench for the MM:SS count-up timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_up_bcd;

    logic        clk = 1'b0;
    logic        rst, enablen, clear, load, tick;
    logic [15:0] load_value, limit;
    logic [15:0] count;
    logic        rco_L, done, running;

    logic        s_rst = 1'b1, s_enablen = 1'b1, s_clear = 1'b0, s_load = 1'b0;
    logic [15:0] s_lv = 16'h0000, s_limit = 16'h0000;

    typedef struct {
        bit          chk;
        logic [15:0] exp_count;
        logic        exp_done;
        logic        exp_running;
        logic        exp_rco;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    timer_up_bcd dut (
        .clk       (clk),
        .rst       (rst),
        .enablen   (enablen),
        .clear     (clear),
        .load      (load),
        .load_value(load_value),
        .limit     (limit),
        .tick      (tick),
        .count     (count),
        .rco_L     (rco_L),
        .done      (done),
        .running   (running)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic compare(input string nm, input string field,
                           input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h, expected %h", nm, field, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what must follow.
    task automatic cyc(input logic tk, input bit chk, input logic [15:0] ec,
                       input logic ed, input logic er, input logic erco,
                       input string nm);
        exp_t e;
        @(negedge clk);
        rst        = s_rst;
        enablen    = s_enablen;
        clear      = s_clear;
        load       = s_load;
        load_value = s_lv;
        limit      = s_limit;
        tick       = tk;
        e.chk = chk; e.exp_count = ec; e.exp_done = ed;
        e.exp_running = er; e.exp_rco = erco; e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: rco_L is checked against the applied inputs, the rest after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.chk) compare(e.name, "rco_L", {15'd0, rco_L}, {15'd0, e.exp_rco});
                @(posedge clk);
                #1;
                if (e.chk) begin
                    compare(e.name, "count", count, e.exp_count);
                    compare(e.name, "done", {15'd0, done}, {15'd0, e.exp_done});
                    compare(e.name, "running", {15'd0, running}, {15'd0, e.exp_running});
                end
            end
        end
    end

    initial begin
        // Reset dominates a simultaneous load.
        s_rst = 1'b1; s_load = 1'b1; s_lv = 16'h1234;
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, "rst_pre");
        cyc(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, "reset");
        s_rst = 1'b0; s_lv = 16'h0A7F;
        cyc(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, "load_0A7F");
        s_lv = 16'h5A79;
        cyc(1'b0, 1'b1, 16'h5009, 1'b0, 1'b0, 1'b1, "load_5A79");

        // Basic counting across the seconds/minutes boundary.
        s_lv = 16'h0058; s_limit = 16'h0000;
        cyc(1'b0, 1'b1, 16'h0058, 1'b0, 1'b0, 1'b1, "load_0058");
        s_load = 1'b0; s_enablen = 1'b0;
        cyc(1'b1, 1'b1, 16'h0058, 1'b0, 1'b1, 1'b1, "idle_to_run");
        cyc(1'b1, 1'b1, 16'h0059, 1'b0, 1'b1, 1'b1, "tick1");
        cyc(1'b1, 1'b1, 16'h0100, 1'b0, 1'b1, 1'b1, "tick2");
        cyc(1'b1, 1'b1, 16'h0101, 1'b0, 1'b1, 1'b1, "tick3");

        // Pause, resume, load beats tick.
        s_enablen = 1'b1;
        cyc(1'b1, 1'b1, 16'h0101, 1'b0, 1'b0, 1'b1, "pause_enter");
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, 16'h0101, 1'b0, 1'b0, 1'b1, "pause_hold");
        s_enablen = 1'b0;
        cyc(1'b1, 1'b1, 16'h0101, 1'b0, 1'b1, 1'b1, "resume");
        cyc(1'b1, 1'b1, 16'h0102, 1'b0, 1'b1, 1'b1, "resume_tick");
        s_load = 1'b1; s_lv = 16'h0300;
        cyc(1'b1, 1'b1, 16'h0300, 1'b0, 1'b0, 1'b1, "load_vs_tick");

        // Reaching the limit.
        s_lv = 16'h0955; s_limit = 16'h1000;
        cyc(1'b0, 1'b1, 16'h0955, 1'b0, 1'b0, 1'b1, "load_0955");
        s_load = 1'b0;
        cyc(1'b0, 1'b1, 16'h0955, 1'b0, 1'b1, 1'b1, "run_0955");
        cyc(1'b1, 1'b1, 16'h0956, 1'b0, 1'b1, 1'b1, "lim_t1");
        cyc(1'b1, 1'b1, 16'h0957, 1'b0, 1'b1, 1'b1, "lim_t2");
        cyc(1'b1, 1'b1, 16'h0958, 1'b0, 1'b1, 1'b1, "lim_t3");
        cyc(1'b1, 1'b1, 16'h0959, 1'b0, 1'b1, 1'b1, "lim_t4");
        cyc(1'b1, 1'b1, 16'h1000, 1'b1, 1'b0, 1'b1, "done_reach");
        cyc(1'b1, 1'b1, 16'h1000, 1'b1, 1'b0, 1'b1, "done_hold");
        s_enablen = 1'b1;
        cyc(1'b1, 1'b1, 16'h1000, 1'b1, 1'b0, 1'b1, "done_hold_en");
        s_enablen = 1'b0;
        cyc(1'b1, 1'b1, 16'h1000, 1'b1, 1'b0, 1'b1, "done_hold2");
        s_clear = 1'b1;
        cyc(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, "clear");
        s_clear = 1'b0;

        // Full rollover and ripple carry.
        s_load = 1'b1; s_lv = 16'h9958; s_limit = 16'h0000;
        cyc(1'b0, 1'b1, 16'h9958, 1'b0, 1'b0, 1'b1, "load_9958");
        s_load = 1'b0;
        cyc(1'b0, 1'b1, 16'h9958, 1'b0, 1'b1, 1'b1, "run_9958");
        cyc(1'b1, 1'b1, 16'h9959, 1'b0, 1'b1, 1'b1, "to_9959");
        cyc(1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, "rollover");
        cyc(1'b1, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, "post_roll");
        s_rst = 1'b1;
        cyc(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, "rst_mid");
        s_rst = 1'b0;

        // Load at 99:59 with a tick: load wins, rco_L still asserts.
        s_load = 1'b1; s_lv = 16'h9958;
        cyc(1'b0, 1'b1, 16'h9958, 1'b0, 1'b0, 1'b1, "load_9958b");
        s_load = 1'b0;
        cyc(1'b0, 1'b1, 16'h9958, 1'b0, 1'b1, 1'b1, "run_9958b");
        cyc(1'b1, 1'b1, 16'h9959, 1'b0, 1'b1, 1'b1, "to_9959b");
        s_load = 1'b1; s_lv = 16'h0000;
        cyc(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, "load_at_max");

        // Start value equal to limit: done only after a full wrap.
        s_lv = 16'h0002; s_limit = 16'h0002;
        cyc(1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, "load_0002");
        s_load = 1'b0;
        cyc(1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b1, "run_0002");
        cyc(1'b1, 1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, "eq_t1");
        for (int k = 2; k <= 5996; k++)
            cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, "eq_run");
        cyc(1'b1, 1'b1, 16'h9959, 1'b0, 1'b1, 1'b1, "eq_t5997");
        cyc(1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, "eq_wrap");
        cyc(1'b1, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, "eq_t5999");
        cyc(1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, "eq_done");
        cyc(1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, "eq_hold");
        s_rst = 1'b1;
        cyc(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, "rst_done");
        s_rst = 1'b0;

        // Limit changed while running applies to the next advance.
        s_load = 1'b1; s_lv = 16'h0010; s_limit = 16'h0000;
        cyc(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b1, "load_0010");
        s_load = 1'b0;
        cyc(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1, 1'b1, "run_0010");
        cyc(1'b1, 1'b1, 16'h0011, 1'b0, 1'b1, 1'b1, "free_0011");
        s_limit = 16'h0012;
        cyc(1'b1, 1'b1, 16'h0012, 1'b1, 1'b0, 1'b1, "lim_change");

        repeat (2) @(negedge clk);
        #5;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
